// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the memory port arbiter.
//   state_t   : sequencing state (IDLE/ISSUE/WAIT)
//   owner_t   : requester that currently owns the memory port
//   FETCH_MASK: byte enables driven for instruction fetches
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    IMEM = 2'd1,
    DMEM = 2'd2
  } owner_t;

  localparam logic [3:0] FETCH_MASK = 4'b1111;

  // The memory macro is word addressed; byte offsets are carried by the mask.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch stage, the mem stage, the memory macro and
// the arbiter.
//   slave  : arbiter view (requests and memory read data in; acks, read
//            data, stalls and memory strobes out)
//   master : requester/memory view (the opposite directions)
interface mem_port_arbiter_if;

  logic        i_imem_req;
  logic [31:0] i_imem_addr;
  logic [31:0] o_imem_rdata;
  logic        o_imem_ack;
  logic        o_imem_stall;

  logic        i_dmem_rd_en;
  logic        i_dmem_wr_en;
  logic [31:0] i_dmem_addr;
  logic [31:0] i_dmem_wdata;
  logic [3:0]  i_dmem_mask;
  logic [31:0] o_dmem_rdata;
  logic        o_dmem_ack;
  logic        o_dmem_stall;

  logic [31:0] o_mem_addr;
  logic        o_mem_ren;
  logic        o_mem_wen;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_mask;
  logic [31:0] i_mem_rdata;

  logic        o_proto_err;

  modport slave (
    input  i_imem_req, i_imem_addr,
    input  i_dmem_rd_en, i_dmem_wr_en, i_dmem_addr, i_dmem_wdata, i_dmem_mask,
    input  i_mem_rdata,
    output o_imem_rdata, o_imem_ack, o_imem_stall,
    output o_dmem_rdata, o_dmem_ack, o_dmem_stall,
    output o_mem_addr, o_mem_ren, o_mem_wen, o_mem_wdata, o_mem_mask,
    output o_proto_err
  );

  modport master (
    output i_imem_req, i_imem_addr,
    output i_dmem_rd_en, i_dmem_wr_en, i_dmem_addr, i_dmem_wdata, i_dmem_mask,
    output i_mem_rdata,
    input  o_imem_rdata, o_imem_ack, o_imem_stall,
    input  o_dmem_rdata, o_dmem_ack, o_dmem_stall,
    input  o_mem_addr, o_mem_ren, o_mem_wen, o_mem_wdata, o_mem_mask,
    input  o_proto_err
  );

endinterface

// File: rtl/mem_port_arbiter_grant_select.sv
// Grant decision between fetch and data requests, with the data streak
// counter that bounds fetch starvation.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   in_idle      : arbiter is in IDLE; grants and streak updates only then
//   imem_req     : fetch request pending
//   dmem_req     : data read or write pending
//   grant_imem   : fetch wins this IDLE cycle
//   grant_dmem   : data wins this IDLE cycle
module mem_grant_select #(
  parameter int unsigned MAX_DATA_STREAK = 4,
  parameter int unsigned CNT_W           = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic in_idle,
  input  logic imem_req,
  input  logic dmem_req,
  output logic grant_imem,
  output logic grant_dmem
);

  localparam logic [CNT_W-1:0] STREAK_MAX = CNT_W'(MAX_DATA_STREAK);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic [CNT_W-1:0] streak;
  logic             fetch_turn;

  // Data normally wins; a waiting fetch takes the port once data has had
  // MAX_DATA_STREAK grants in a row while it waited.
  always_comb begin
    fetch_turn = imem_req && (streak == STREAK_MAX);
    grant_dmem = in_idle && dmem_req && !fetch_turn;
    grant_imem = in_idle && imem_req && !grant_dmem;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      streak <= '0;
    end else if (in_idle) begin
      if (!imem_req || grant_imem) begin
        streak <= '0;
      end else if (grant_dmem) begin
        streak <= streak + CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch (read only)
// and the mem stage (load/store). Each access is granted in IDLE, issued
// for exactly one cycle, waits out the memory read latency, then the
// owner gets a one-cycle ack.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   bus          : fetch, data and memory signals (slave modport)
// Parameters:
//   RD_LATENCY      : cycles from issue to valid memory read data (>=1)
//   MAX_DATA_STREAK : data grants in a row allowed while a fetch waits (>=1)
//   CNT_W           : width of latency and streak counters
module mem_port_arbiter #(
  parameter int unsigned RD_LATENCY      = 1,
  parameter int unsigned MAX_DATA_STREAK = 4,
  parameter int unsigned CNT_W           = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  mem_port_arbiter_if.slave  bus
);
  import mem_port_arbiter_pkg::*;

  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(RD_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state;
  owner_t           owner;
  logic [CNT_W-1:0] lat_cnt;
  logic             is_read;
  logic             mem_ren;
  logic             mem_wen;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_wdata;
  logic [3:0]       mem_mask;
  logic             imem_ack;
  logic             dmem_ack;

  logic             dmem_req;
  logic             grant_imem;
  logic             grant_dmem;
  logic [CNT_W-1:0] lat_next;

  assign dmem_req = bus.i_dmem_rd_en | bus.i_dmem_wr_en;
  assign lat_next = is_read ? LAT_LOAD : '0;

  mem_grant_select #(
    .MAX_DATA_STREAK (MAX_DATA_STREAK),
    .CNT_W           (CNT_W)
  ) u_grant_select (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .in_idle    (state == IDLE),
    .imem_req   (bus.i_imem_req),
    .dmem_req   (dmem_req),
    .grant_imem (grant_imem),
    .grant_dmem (grant_dmem)
  );

  // Acks are registered one cycle ahead: they are set on the edge that
  // enters the WAIT cycle in which the latency counter reads zero.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= IDLE;
      owner     <= NONE;
      lat_cnt   <= '0;
      is_read   <= 1'b0;
      mem_ren   <= 1'b0;
      mem_wen   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_mask  <= '0;
      imem_ack  <= 1'b0;
      dmem_ack  <= 1'b0;
    end else begin
      imem_ack <= 1'b0;
      dmem_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_dmem) begin
            // A request with both enables set is performed as a write.
            owner     <= DMEM;
            is_read   <= !bus.i_dmem_wr_en;
            mem_ren   <= !bus.i_dmem_wr_en;
            mem_wen   <= bus.i_dmem_wr_en;
            mem_addr  <= word_align(bus.i_dmem_addr);
            mem_wdata <= bus.i_dmem_wdata;
            mem_mask  <= bus.i_dmem_mask;
            state     <= ISSUE;
          end else if (grant_imem) begin
            owner    <= IMEM;
            is_read  <= 1'b1;
            mem_ren  <= 1'b1;
            mem_wen  <= 1'b0;
            mem_addr <= word_align(bus.i_imem_addr);
            mem_mask <= FETCH_MASK;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          mem_ren <= 1'b0;
          mem_wen <= 1'b0;
          lat_cnt <= lat_next;
          state   <= WAIT;
          if (lat_next == '0) begin
            imem_ack <= (owner == IMEM);
            dmem_ack <= (owner == DMEM);
          end
        end
        WAIT: begin
          if (lat_cnt == '0) begin
            owner <= NONE;
            state <= IDLE;
          end else begin
            lat_cnt <= lat_cnt - CNT_ONE;
            if (lat_cnt == CNT_ONE) begin
              imem_ack <= (owner == IMEM);
              dmem_ack <= (owner == DMEM);
            end
          end
        end
        default: begin
          owner <= NONE;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.o_mem_addr  = mem_addr;
  assign bus.o_mem_ren   = mem_ren;
  assign bus.o_mem_wen   = mem_wen;
  assign bus.o_mem_wdata = mem_wdata;
  assign bus.o_mem_mask  = mem_mask;

  assign bus.o_imem_ack   = imem_ack;
  assign bus.o_dmem_ack   = dmem_ack;
  assign bus.o_imem_rdata = imem_ack ? bus.i_mem_rdata : '0;
  assign bus.o_dmem_rdata = (dmem_ack && is_read) ? bus.i_mem_rdata : '0;

  // Stalls and the protocol error depend on live request inputs, so they
  // are gated by reset to keep every output at zero while reset is held.
  assign bus.o_imem_stall = !i_rst && bus.i_imem_req && !imem_ack;
  assign bus.o_dmem_stall = !i_rst && dmem_req && !dmem_ack;
  assign bus.o_proto_err  = !i_rst && grant_dmem
                            && bus.i_dmem_rd_en && bus.i_dmem_wr_en;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int MAX_STREAK = 4;

  typedef logic [138:0] obs_t;

  typedef struct {
    string       name;
    logic        ireq;
    logic [31:0] iaddr;
    logic        rd;
    logic        wr;
    logic [31:0] daddr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic [31:0] mrdata;
    logic        ren;
    logic        wen;
    logic [31:0] maddr;
    logic [3:0]  mmask;
    logic [31:0] mwdata;
    logic        iack;
    logic        dack;
    logic        istall;
    logic        dstall;
    logic        perr;
    logic [31:0] irdata;
    logic [31:0] drdata;
  } vec_t;

  logic clk = 1'b0;
  logic rst1;
  logic rst3;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if if1();
  mem_port_arbiter_if if3();

  mem_port_arbiter #(.RD_LATENCY(1), .MAX_DATA_STREAK(MAX_STREAK), .CNT_W(4)) dut1 (
    .i_clk (clk),
    .i_rst (rst1),
    .bus   (if1)
  );

  mem_port_arbiter #(.RD_LATENCY(3), .MAX_DATA_STREAK(MAX_STREAK), .CNT_W(4)) dut3 (
    .i_clk (clk),
    .i_rst (rst3),
    .bus   (if3)
  );

  function automatic obs_t obs1();
    return {if1.o_mem_ren, if1.o_mem_wen, if1.o_mem_addr, if1.o_mem_mask, if1.o_mem_wdata,
            if1.o_imem_ack, if1.o_dmem_ack, if1.o_imem_stall, if1.o_dmem_stall,
            if1.o_proto_err, if1.o_imem_rdata, if1.o_dmem_rdata};
  endfunction

  function automatic obs_t obs3();
    return {if3.o_mem_ren, if3.o_mem_wen, if3.o_mem_addr, if3.o_mem_mask, if3.o_mem_wdata,
            if3.o_imem_ack, if3.o_dmem_ack, if3.o_imem_stall, if3.o_dmem_stall,
            if3.o_proto_err, if3.o_imem_rdata, if3.o_dmem_rdata};
  endfunction

  function automatic obs_t mk_obs(logic ren, logic wen, logic [31:0] maddr, logic [3:0] mmask,
                                  logic [31:0] mwdata, logic iack, logic dack, logic istall,
                                  logic dstall, logic perr, logic [31:0] irdata,
                                  logic [31:0] drdata);
    return {ren, wen, maddr, mmask, mwdata, iack, dack, istall, dstall, perr, irdata, drdata};
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive1(input logic ireq, input logic [31:0] iaddr, input logic rd,
                        input logic wr, input logic [31:0] daddr, input logic [31:0] wdata,
                        input logic [3:0] mask, input logic [31:0] mrdata);
    if1.i_imem_req = ireq;  if1.i_imem_addr = iaddr;
    if1.i_dmem_rd_en = rd;  if1.i_dmem_wr_en = wr;
    if1.i_dmem_addr = daddr; if1.i_dmem_wdata = wdata; if1.i_dmem_mask = mask;
    if1.i_mem_rdata = mrdata;
  endtask

  task automatic drive3(input logic ireq, input logic [31:0] iaddr, input logic rd,
                        input logic wr, input logic [31:0] daddr, input logic [31:0] wdata,
                        input logic [3:0] mask, input logic [31:0] mrdata);
    if3.i_imem_req = ireq;  if3.i_imem_addr = iaddr;
    if3.i_dmem_rd_en = rd;  if3.i_dmem_wr_en = wr;
    if3.i_dmem_addr = daddr; if3.i_dmem_wdata = wdata; if3.i_dmem_mask = mask;
    if3.i_mem_rdata = mrdata;
  endtask

  task automatic step_in();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t vecs[$];
    int   n_ack;
    int   cyc;
    int   a_cyc;
    int   i_cyc;
    logic [4:0] order;
    logic ack_seen;
    logic [31:0] mr;

    rst1 = 1'b1;
    rst3 = 1'b1;
    drive1(1'b1, 32'h40, 1'b1, 1'b0, 32'h80, 32'h0, 4'hF, 32'hFFFF_FFFF);
    drive3(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0);

    // Reset state, including with requests held (stall must stay low).
    repeat (2) step_in();
    @(negedge clk);
    check("reset_outputs", obs1(), '0);
    check("reset_outputs3", obs3(), '0);
    step_in();
    drive1(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0);
    rst1 = 1'b0;
    rst3 = 1'b0;

    //                name        ireq iaddr        rd wr daddr        wdata         mask   mrdata        ren wen maddr        mmask mwdata        iack dack ist dst perr irdata        drdata
    vecs.push_back(vec_t'{"fetch_t0", 1, 32'h104, 0, 0, 32'h0,   32'h0,         4'h0, 32'h0,         0, 0, 32'h0,   4'h0, 32'h0,         0, 0, 1, 0, 0, 32'h0,         32'h0});
    vecs.push_back(vec_t'{"fetch_t1", 1, 32'h104, 0, 0, 32'h0,   32'h0,         4'h0, 32'h0,         1, 0, 32'h104, 4'hF, 32'h0,         0, 0, 1, 0, 0, 32'h0,         32'h0});
    vecs.push_back(vec_t'{"fetch_t2", 1, 32'h104, 0, 0, 32'h0,   32'h0,         4'h0, 32'hDEADBEEF,  0, 0, 32'h104, 4'hF, 32'h0,         1, 0, 0, 0, 0, 32'hDEADBEEF,  32'h0});
    vecs.push_back(vec_t'{"idle_a",   0, 32'h0,   0, 0, 32'h0,   32'h0,         4'h0, 32'h12345678,  0, 0, 32'h104, 4'hF, 32'h0,         0, 0, 0, 0, 0, 32'h0,         32'h0});
    vecs.push_back(vec_t'{"wr_t0",    0, 32'h0,   0, 1, 32'h203, 32'h5A000000,  4'h8, 32'h0,         0, 0, 32'h104, 4'hF, 32'h0,         0, 0, 0, 1, 0, 32'h0,         32'h0});
    vecs.push_back(vec_t'{"wr_t1",    0, 32'h0,   0, 1, 32'h203, 32'h5A000000,  4'h8, 32'h0,         0, 1, 32'h200, 4'h8, 32'h5A000000,  0, 0, 0, 1, 0, 32'h0,         32'h0});
    vecs.push_back(vec_t'{"wr_t2",    0, 32'h0,   0, 1, 32'h203, 32'h5A000000,  4'h8, 32'h11111111,  0, 0, 32'h200, 4'h8, 32'h5A000000,  0, 1, 0, 0, 0, 32'h0,         32'h0});
    vecs.push_back(vec_t'{"idle_b",   0, 32'h0,   0, 0, 32'h0,   32'h0,         4'h0, 32'h0,         0, 0, 32'h200, 4'h8, 32'h5A000000,  0, 0, 0, 0, 0, 32'h0,         32'h0});
    vecs.push_back(vec_t'{"perr_t0",  0, 32'h0,   1, 1, 32'h10,  32'h12345678,  4'hF, 32'h0,         0, 0, 32'h200, 4'h8, 32'h5A000000,  0, 0, 0, 1, 1, 32'h0,         32'h0});
    vecs.push_back(vec_t'{"perr_t1",  0, 32'h0,   1, 1, 32'h10,  32'h12345678,  4'hF, 32'h0,         0, 1, 32'h10,  4'hF, 32'h12345678,  0, 0, 0, 1, 0, 32'h0,         32'h0});
    vecs.push_back(vec_t'{"perr_t2",  0, 32'h0,   1, 1, 32'h10,  32'h12345678,  4'hF, 32'hAAAA5555,  0, 0, 32'h10,  4'hF, 32'h12345678,  0, 1, 0, 0, 0, 32'h0,         32'h0});
    vecs.push_back(vec_t'{"idle_c",   0, 32'h0,   0, 0, 32'h0,   32'h0,         4'h0, 32'h0,         0, 0, 32'h10,  4'hF, 32'h12345678,  0, 0, 0, 0, 0, 32'h0,         32'h0});
    vecs.push_back(vec_t'{"rd_t0",    0, 32'h0,   1, 0, 32'h47,  32'h0,         4'h3, 32'h0,         0, 0, 32'h10,  4'hF, 32'h12345678,  0, 0, 0, 1, 0, 32'h0,         32'h0});
    vecs.push_back(vec_t'{"rd_t1",    0, 32'h0,   1, 0, 32'h47,  32'h0,         4'h3, 32'h0,         1, 0, 32'h44,  4'h3, 32'h0,         0, 0, 0, 1, 0, 32'h0,         32'h0});
    vecs.push_back(vec_t'{"rd_t2",    0, 32'h0,   1, 0, 32'h47,  32'h0,         4'h3, 32'hCAFEF00D,  0, 0, 32'h44,  4'h3, 32'h0,         0, 1, 0, 0, 0, 32'h0,         32'hCAFEF00D});
    vecs.push_back(vec_t'{"idle_d",   0, 32'h0,   0, 0, 32'h0,   32'h0,         4'h0, 32'h0,         0, 0, 32'h44,  4'h3, 32'h0,         0, 0, 0, 0, 0, 32'h0,         32'h0});
    vecs.push_back(vec_t'{"fetch2_t0",1, 32'h207, 0, 0, 32'h0,   32'h0,         4'h0, 32'h0,         0, 0, 32'h44,  4'h3, 32'h0,         0, 0, 1, 0, 0, 32'h0,         32'h0});
    vecs.push_back(vec_t'{"fetch2_t1",1, 32'h207, 0, 0, 32'h0,   32'h0,         4'h0, 32'h0,         1, 0, 32'h204, 4'hF, 32'h0,         0, 0, 1, 0, 0, 32'h0,         32'h0});
    vecs.push_back(vec_t'{"fetch2_t2",1, 32'h207, 0, 0, 32'h0,   32'h0,         4'h0, 32'h0BADF00D,  0, 0, 32'h204, 4'hF, 32'h0,         1, 0, 0, 0, 0, 32'h0BADF00D,  32'h0});
    vecs.push_back(vec_t'{"idle_e",   0, 32'h0,   0, 0, 32'h0,   32'h0,         4'h0, 32'h0,         0, 0, 32'h204, 4'hF, 32'h0,         0, 0, 0, 0, 0, 32'h0,         32'h0});

    foreach (vecs[k]) begin
      step_in();
      drive1(vecs[k].ireq, vecs[k].iaddr, vecs[k].rd, vecs[k].wr, vecs[k].daddr,
             vecs[k].wdata, vecs[k].mask, vecs[k].mrdata);
      @(negedge clk);
      check(vecs[k].name, obs1(),
            mk_obs(vecs[k].ren, vecs[k].wen, vecs[k].maddr, vecs[k].mmask, vecs[k].mwdata,
                   vecs[k].iack, vecs[k].dack, vecs[k].istall, vecs[k].dstall, vecs[k].perr,
                   vecs[k].irdata, vecs[k].drdata));
    end

    // Fetch and data held continuously: MAX_STREAK data acks, then the fetch.
    n_ack = 0;
    cyc = 0;
    order = '0;
    while (n_ack < 5 && cyc < 80) begin
      step_in();
      drive1(1'b1, 32'h300, 1'b1, 1'b0, 32'h400, 32'h0, 4'hF, $urandom);
      @(negedge clk);
      cyc++;
      if (if1.o_dmem_ack) begin order = {order[3:0], 1'b0}; n_ack++; end
      if (if1.o_imem_ack) begin order = {order[3:0], 1'b1}; n_ack++; end
    end
    check("arb_ack_count", obs_t'(n_ack), obs_t'(5));
    check("arb_order_DDDDI", obs_t'(order), obs_t'(5'b00001));
    step_in();
    drive1(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0);
    repeat (2) step_in();

    // Fetch and a single data read together: data first, fetch in the next IDLE.
    cyc = 0;
    a_cyc = -1;
    i_cyc = -1;
    while (i_cyc < 0 && cyc < 30) begin
      step_in();
      drive1(1'b1, 32'h500, (a_cyc < 0), 1'b0, 32'h600, 32'h0, 4'hF, 32'h0);
      @(negedge clk);
      if (if1.o_dmem_ack && a_cyc < 0) a_cyc = cyc;
      if (if1.o_imem_ack) i_cyc = cyc;
      cyc++;
    end
    check("fetch_after_data_first", obs_t'(a_cyc >= 0 && (i_cyc > a_cyc)), obs_t'(1));
    check("fetch_after_data_gap", obs_t'(i_cyc - a_cyc), obs_t'(3));
    step_in();
    drive1(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0);

    // RD_LATENCY=3 read: ack 4 cycles after the request, rdata only then.
    ack_seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step_in();
      mr = $urandom;
      drive3(1'b0, 32'h0, !ack_seen, 1'b0, 32'h80, 32'h0, 4'hF, mr);
      @(negedge clk);
      if (if3.o_dmem_ack) begin
        check("l3_ack_cycle", obs_t'(k), obs_t'(4));
        check("l3_rdata_ack", obs_t'(if3.o_dmem_rdata), obs_t'(mr));
        ack_seen = 1'b1;
      end else begin
        check("l3_rdata_idle", obs_t'(if3.o_dmem_rdata), '0);
      end
    end
    check("l3_ack_seen", obs_t'(ack_seen), obs_t'(1));

    // Reset during WAIT: outputs drop at once, no ack, re-request completes.
    for (int k = 0; k < 3; k++) begin
      step_in();
      drive3(1'b0, 32'h0, 1'b1, 1'b0, 32'h90, 32'h0, 4'hF, 32'h77);
    end
    step_in();
    rst3 = 1'b1;
    @(negedge clk);
    check("rst_mid_wait_outputs", obs3(), '0);
    step_in();
    @(negedge clk);
    check("rst_held_no_ack", obs3(), '0);
    ack_seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step_in();
      rst3 = 1'b0;
      drive3(1'b0, 32'h0, !ack_seen, 1'b0, 32'h90, 32'h0, 4'hF, 32'h0000_5EED);
      @(negedge clk);
      if (if3.o_dmem_ack) begin
        check("rst_reissue_cycle", obs_t'(k), obs_t'(4));
        check("rst_reissue_rdata", obs_t'(if3.o_dmem_rdata), obs_t'(32'h0000_5EED));
        ack_seen = 1'b1;
      end
    end
    check("rst_reissue_ack_seen", obs_t'(ack_seen), obs_t'(1));

    // Randomised traffic on the RD_LATENCY=1 instance against a
    // transaction-scheduling reference model.
    step_in();
    rst1 = 1'b1;
    drive1(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0);
    step_in();
    rst1 = 1'b0;
    begin
      int m_free, m_issue, m_ack, m_own, m_streak;
      logic m_read;
      logic [31:0] t_addr, t_wdata, e_addr, e_wdata;
      logic [3:0] t_mask, e_mask;
      logic i_on, d_on, p_iack, p_dack;
      logic [31:0] s_iaddr, s_daddr, s_wdata;
      logic [3:0] s_mask;
      logic s_rd, s_wr;
      logic e_perr, e_iack, e_dack, ri, rdq, wrq, gd, gi;
      int kind;

      m_free = 0; m_issue = -1; m_ack = -1; m_own = 0; m_streak = 0; m_read = 1'b0;
      t_addr = '0; t_wdata = '0; t_mask = '0;
      e_addr = '0; e_wdata = '0; e_mask = '0;
      i_on = 1'b0; d_on = 1'b0; p_iack = 1'b0; p_dack = 1'b0;
      s_iaddr = '0; s_daddr = '0; s_wdata = '0; s_mask = '0; s_rd = 1'b0; s_wr = 1'b0;

      for (int c = 0; c < 800; c++) begin
        step_in();
        if (i_on && p_iack) i_on = ($urandom_range(0, 1) == 1);
        else if (!i_on) i_on = ($urandom_range(0, 2) == 0);
        else if ($urandom_range(0, 31) == 0) i_on = 1'b0;
        if (i_on && (p_iack || !if1.i_imem_req)) s_iaddr = $urandom;
        if (d_on && p_dack) d_on = ($urandom_range(0, 1) == 1);
        else if (!d_on) d_on = ($urandom_range(0, 2) == 0);
        else if ($urandom_range(0, 31) == 0) d_on = 1'b0;
        if (d_on && (p_dack || !(if1.i_dmem_rd_en || if1.i_dmem_wr_en))) begin
          kind = $urandom_range(0, 9);
          s_rd = (kind == 0) || (kind > 4);
          s_wr = (kind <= 4);
          s_daddr = $urandom; s_wdata = $urandom; s_mask = 4'($urandom_range(0, 15));
        end
        drive1(i_on, s_iaddr, d_on && s_rd, d_on && s_wr, s_daddr, s_wdata, s_mask, $urandom);
        @(negedge clk);

        ri  = if1.i_imem_req;
        rdq = if1.i_dmem_rd_en;
        wrq = if1.i_dmem_wr_en;
        e_perr = 1'b0;
        if (c == m_free) begin
          gd = (rdq || wrq) && !(ri && m_streak == MAX_STREAK);
          gi = !gd && ri;
          if (!ri) m_streak = 0;
          else if (gd) m_streak = m_streak + 1;
          else m_streak = 0;
          if (gd) begin
            m_own = 2; m_read = !wrq; t_addr = if1.i_dmem_addr & 32'hFFFF_FFFC;
            t_mask = if1.i_dmem_mask; t_wdata = if1.i_dmem_wdata; e_perr = rdq && wrq;
          end else if (gi) begin
            m_own = 1; m_read = 1'b1; t_addr = if1.i_imem_addr & 32'hFFFF_FFFC;
            t_mask = 4'hF; t_wdata = e_wdata;
          end
          if (gd || gi) begin
            m_issue = c + 1;
            m_ack = m_read ? c + 1 + 1 : c + 2;
            m_free = m_ack + 1;
          end else begin
            m_free = c + 1;
          end
        end
        if (c == m_issue) begin
          e_addr = t_addr; e_mask = t_mask; e_wdata = t_wdata;
        end
        e_iack = (c == m_ack) && (m_own == 1);
        e_dack = (c == m_ack) && (m_own == 2);
        check("random_cycle", obs1(),
              mk_obs((c == m_issue) && m_read, (c == m_issue) && !m_read, e_addr, e_mask,
                     e_wdata, e_iack, e_dack, ri && !e_iack, (rdq || wrq) && !e_dack, e_perr,
                     e_iack ? if1.i_mem_rdata : 32'h0,
                     (e_dack && m_read) ? if1.i_mem_rdata : 32'h0));
        p_iack = if1.o_imem_ack;
        p_dack = if1.o_dmem_ack;
      end
    end
    step_in();
    drive1(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0);
    repeat (4) step_in();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
